// File: rtl/store_align_unit.sv
// Store-side data-memory interface: encodes lane-aligned write data and byte
// enables from funct3/addr, then runs the write handshake until mem_resp.
//
// state | meaning
// IDLE  | waiting for store_req; legal stores captured, illegal ones rejected
// WRITE | mem_write held with captured address/data/enables until mem_resp
// DONE  | one-cycle retire: done (and misaligned if rejected), back to IDLE
module store_align_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        store_req,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] rs2_data,
   input  logic        mem_resp,
   output logic        mem_write,
   output logic [31:0] mem_address,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_byte_enable,
   output logic        stall,
   output logic        done,
   output logic        misaligned
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t state;

   logic        legal;
   logic [3:0]  lane_be;
   logic [31:0] lane_wdata;

   always_comb begin
      legal      = 1'b0;
      lane_be    = 4'b0000;
      lane_wdata = 32'h0;
      case (funct3)
         3'b000: begin
            legal      = 1'b1;
            lane_be    = 4'b0001 << addr[1:0];
            lane_wdata = {4{rs2_data[7:0]}};
         end
         3'b001: begin
            legal      = ~addr[0];
            lane_be    = 4'b0011 << addr[1:0];
            lane_wdata = {2{rs2_data[15:0]}};
         end
         3'b010: begin
            legal      = (addr[1:0] == 2'b00);
            lane_be    = 4'b1111;
            lane_wdata = rs2_data;
         end
         default: begin
            legal      = 1'b0;
            lane_be    = 4'b0000;
            lane_wdata = 32'h0;
         end
      endcase
   end

   // Released during DONE so the pipeline advances exactly once per store.
   assign stall = store_req & (state != DONE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         mem_write       <= 1'b0;
         mem_address     <= 32'h0;
         mem_wdata       <= 32'h0;
         mem_byte_enable <= 4'b0000;
         done            <= 1'b0;
         misaligned      <= 1'b0;
      end else begin
         done       <= 1'b0;
         misaligned <= 1'b0;
         case (state)
            IDLE: begin
               if (store_req) begin
                  if (legal) begin
                     state           <= WRITE;
                     mem_write       <= 1'b1;
                     mem_address     <= {addr[31:2], 2'b00};
                     mem_wdata       <= lane_wdata;
                     mem_byte_enable <= lane_be;
                  end else begin
                     state      <= DONE;
                     done       <= 1'b1;
                     misaligned <= 1'b1;
                  end
               end
            end
            WRITE: begin
               if (mem_resp) begin
                  state     <= DONE;
                  mem_write <= 1'b0;
                  done      <= 1'b1;
               end
            end
            DONE: begin
               state           <= IDLE;
               mem_address     <= 32'h0;
               mem_wdata       <= 32'h0;
               mem_byte_enable <= 4'b0000;
            end
            default: begin
               state     <= IDLE;
               mem_write <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_store_align_unit.sv
// Directed bench for store_align_unit: lane encoding, rejection, reset abort
// and back-to-back stores, with hand-computed expectations.
module tb_store_align_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        store_req;
   logic [2:0]  funct3;
   logic [31:0] addr;
   logic [31:0] rs2_data;
   logic        mem_resp;
   logic        mem_write;
   logic [31:0] mem_address;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_byte_enable;
   logic        stall;
   logic        done;
   logic        misaligned;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   store_align_unit dut (
      .clk             (clk),
      .rst             (rst),
      .store_req       (store_req),
      .funct3          (funct3),
      .addr            (addr),
      .rs2_data        (rs2_data),
      .mem_resp        (mem_resp),
      .mem_write       (mem_write),
      .mem_address     (mem_address),
      .mem_wdata       (mem_wdata),
      .mem_byte_enable (mem_byte_enable),
      .stall           (stall),
      .done            (done),
      .misaligned      (misaligned)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, " idle mem_write"}, {31'h0, mem_write}, 32'h0);
      check({tag, " idle mem_address"}, mem_address, 32'h0);
      check({tag, " idle mem_wdata"}, mem_wdata, 32'h0);
      check({tag, " idle byte_enable"}, {28'h0, mem_byte_enable}, 32'h0);
      check({tag, " idle done"}, {31'h0, done}, 32'h0);
      check({tag, " idle misaligned"}, {31'h0, misaligned}, 32'h0);
   endtask

   // Issue one store, answer after nwrite WRITE cycles, and check the handshake.
   task automatic run_store(input string tag, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] d, input int nwrite, input logic exp_ok,
                            input logic [3:0] exp_be, input logic [31:0] exp_wd);
      int wcyc = 0;
      bit got_done = 0;
      bit stall_bad = 0;
      @(posedge clk); #1;
      store_req = 1'b1;
      funct3    = f3;
      addr      = a;
      rs2_data  = d;
      mem_resp  = 1'b0;
      for (int c = 0; c < 40 && !got_done; c++) begin
         @(negedge clk);
         if (mem_write) begin
            wcyc++;
            check({tag, " mem_address"}, mem_address, {a[31:2], 2'b00});
            check({tag, " byte_enable"}, {28'h0, mem_byte_enable}, {28'h0, exp_be});
            check({tag, " mem_wdata"}, mem_wdata, exp_wd);
            mem_resp = (wcyc == nwrite);
         end else begin
            mem_resp = 1'b0;
         end
         if (done) begin
            got_done  = 1;
            check({tag, " stall at done"}, {31'h0, stall}, 32'h0);
            check({tag, " misaligned"}, {31'h0, misaligned}, {31'h0, ~exp_ok});
            store_req = 1'b0;
            mem_resp  = 1'b0;
         end else if (!stall) begin
            stall_bad = 1;
         end
      end
      check({tag, " done seen"}, {31'h0, got_done}, 32'h1);
      check({tag, " stall held"}, {31'h0, stall_bad}, 32'h0);
      check({tag, " write cycles"}, wcyc, exp_ok ? nwrite : 0);
      @(negedge clk);
      check_idle(tag);
   endtask

   initial begin
      int wcyc, dcnt, cyc, last_done, gap;
      bit gap_bad;
      rst       = 1'b1;
      store_req = 1'b0;
      funct3    = 3'b000;
      addr      = 32'h0;
      rs2_data  = 32'h0;
      mem_resp  = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_idle("reset");
      check("reset stall low", {31'h0, stall}, 32'h0);
      store_req = 1'b1;
      #1;
      check("reset stall follows req", {31'h0, stall}, 32'h1);
      store_req = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;

      run_store("sw 0x100", 3'b010, 32'h100, 32'hDEADBEEF, 2, 1'b1, 4'b1111, 32'hDEADBEEF);
      run_store("sb 0x200", 3'b000, 32'h200, 32'h000000A5, 1, 1'b1, 4'b0001, 32'hA5A5A5A5);
      run_store("sb 0x201", 3'b000, 32'h201, 32'h000000A5, 1, 1'b1, 4'b0010, 32'hA5A5A5A5);
      run_store("sb 0x202", 3'b000, 32'h202, 32'h000000A5, 1, 1'b1, 4'b0100, 32'hA5A5A5A5);
      run_store("sb 0x203", 3'b000, 32'h203, 32'h000000A5, 3, 1'b1, 4'b1000, 32'hA5A5A5A5);
      run_store("sh 0x300", 3'b001, 32'h300, 32'h1234BEEF, 1, 1'b1, 4'b0011, 32'hBEEFBEEF);
      run_store("sh 0x302", 3'b001, 32'h302, 32'h1234BEEF, 1, 1'b1, 4'b1100, 32'hBEEFBEEF);
      run_store("sh 0x301", 3'b001, 32'h301, 32'h1234BEEF, 1, 1'b0, 4'b0000, 32'h0);
      run_store("f3 011",   3'b011, 32'h40,  32'h55555555, 1, 1'b0, 4'b0000, 32'h0);
      run_store("sw 0x102", 3'b010, 32'h102, 32'hCAFEF00D, 1, 1'b0, 4'b0000, 32'h0);

      // Reset in the middle of a write aborts it without a done pulse.
      @(posedge clk); #1;
      store_req = 1'b1;
      funct3    = 3'b010;
      addr      = 32'h500;
      rs2_data  = 32'h13579BDF;
      wcyc = 0;
      for (int c = 0; c < 10 && wcyc == 0; c++) begin
         @(negedge clk);
         if (mem_write) wcyc++;
      end
      check("rst-mid write started", wcyc, 1);
      rst = 1'b1;
      @(negedge clk);
      check("rst-mid mem_write", {31'h0, mem_write}, 32'h0);
      rst       = 1'b0;
      store_req = 1'b0;
      mem_resp  = 1'b1;
      dcnt = 0;
      wcyc = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         mem_resp = 1'b0;
         if (done) dcnt++;
         if (mem_write) wcyc++;
      end
      check("rst-mid done pulses", dcnt, 0);
      check("rst-mid late writes", wcyc, 0);
      check_idle("rst-mid");

      // Back-to-back stores with req held and mem_resp stuck high.
      @(posedge clk); #1;
      store_req = 1'b1;
      funct3    = 3'b010;
      addr      = 32'h600;
      rs2_data  = 32'h0BADF00D;
      mem_resp  = 1'b1;
      wcyc = 0; dcnt = 0; cyc = 0; last_done = -1; gap_bad = 0;
      for (int c = 0; c < 30 && dcnt < 2; c++) begin
         @(negedge clk);
         cyc++;
         if (mem_write) begin
            wcyc++;
            if (last_done >= 0) begin
               gap = cyc - last_done;
               if (gap != 2) gap_bad = 1;
            end
         end
         if (done) begin
            dcnt++;
            last_done = cyc;
            if (dcnt == 2) store_req = 1'b0;
         end
      end
      check("b2b done pulses", dcnt, 2);
      check("b2b write cycles", wcyc, 2);
      check("b2b one idle cycle", {31'h0, gap_bad}, 32'h0);
      wcyc = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (mem_write || done) wcyc++;
      end
      mem_resp = 1'b0;
      check("b2b no third store", wcyc, 0);
      check_idle("b2b");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/store_align_unit.md
# store_align_unit

Store-side data-memory interface for the pipelined RV32I core; the write-direction counterpart of the load data register that sign/zero-extends read data. It accepts a store request from the MEM stage, encodes byte enables and lane-aligned write data from funct3 and address, and drives the data-memory write handshake until the memory responds. It stalls the pipeline while the write is outstanding and flags misaligned or invalid stores without touching memory.

## Interface

- No parameters; data path fixed at 32 bits.
- clk  input  1  core clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- store_req  input  1  MEM stage has a store; held until done
- funct3  input  3  store width: 000 sb, 001 sh, 010 sw; other codes invalid
- addr  input  32  byte address from ALU
- rs2_data  input  32  unaligned store data; low byte/half/word used
- mem_resp  input  1  data memory write complete, one-cycle pulse
- mem_write  output  1  write request to data memory
- mem_address  output  32  word-aligned address, {addr[31:2], 2'b00}
- mem_wdata  output  32  lane-aligned write data
- mem_byte_enable  output  4  byte enables, bit i = byte lane i
- stall  output  1  hold the pipeline
- done  output  1  one-cycle pulse: store retired
- misaligned  output  1  one-cycle pulse: store rejected, no write

## Operation

- FSM states: IDLE, WRITE, DONE.
- IDLE, store_req=1, legal and aligned: capture mem_address, mem_wdata, mem_byte_enable; go to WRITE.
- IDLE, store_req=1, illegal (invalid funct3, sh with addr[0]=1, sw with addr[1:0]!=0): no capture; go to DONE with misaligned pulse registered.
- WRITE: mem_write=1, outputs held constant; mem_resp=1 -> DONE; otherwise stay (no timeout).
- DONE: done=1 for exactly one cycle (misaligned=1 too if rejected); unconditionally -> IDLE. store_req during DONE ignored.
- Lane rules, k=addr[1:0]: sb -> byte_enable = 4'b0001 << k, wdata = {4{rs2_data[7:0]}}; sh -> byte_enable = 4'b0011 << k (k in {0,2}), wdata = {2{rs2_data[15:0]}}; sw -> 4'b1111, wdata = rs2_data.
- Replicated data is written to all lanes; only enabled lanes are meaningful.
- mem_resp outside WRITE ignored.
- stall = store_req & (state != DONE), combinational; deasserted the cycle done pulses so the pipeline advances exactly once per store.

## Timing

- Reset values: state IDLE; mem_write 0, mem_address 0, mem_wdata 0, mem_byte_enable 0, done 0, misaligned 0; stall follows store_req.
- Accept edge: store_req sampled in IDLE at edge N; mem_write=1 from N+1.
- Minimum latency (mem_resp in first WRITE cycle): request at edge N, done high in cycle after edge N+2; 3 cycles store_req-to-release.
- Rejected store: done and misaligned high cycle after edge N+1; mem_write never asserts.
- After DONE, IDLE may accept a new request on the very next edge (back-to-back stores: one idle cycle between writes).
- mem_byte_enable, mem_wdata, mem_address zeroed on return to IDLE.
- rst high mid-WRITE: next edge state IDLE, mem_write 0; late mem_resp ignored; no done pulse.
- rst dominates all other inputs in the same cycle.

## Test plan

- sw, addr 0x100, rs2 0xDEADBEEF, mem_resp after 2 WRITE cycles -> mem_address 0x100, byte_enable 1111, wdata 0xDEADBEEF, mem_write 2 cycles, single done pulse, stall drops with done.
- sb sweep addr 0x200..0x203, rs2 0x000000A5 -> byte_enable 0001/0010/0100/1000, wdata 0xA5A5A5A5, mem_address 0x200 each.
- sh addr 0x302, rs2 0x1234BEEF -> byte_enable 1100, wdata 0xBEEFBEEF, mem_address 0x300; sh addr 0x301 -> misaligned+done pulse, mem_write never high.
- funct3 011 any addr -> misaligned pulse, no write; sw addr 0x102 -> misaligned.
- rst asserted during WRITE, then mem_resp pulses -> mem_write low after reset edge, done never pulses, all outputs zero.
- Two back-to-back sw with store_req held -> exactly two write handshakes, two done pulses, one IDLE cycle between, mem_resp in IDLE ignored.
